// File: rtl/register_file_pkg.sv
// Shared widths and bundle types for the architectural register file.
// Imported by the read ports and the register file top.
package register_file_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_WIDTH = 5;
  localparam int VAL_WIDTH = 32;
  localparam int ID_WIDTH  = 4;
  localparam int ROB_SIZE  = 1 << ID_WIDTH;

  typedef logic [REG_NUM-1:0][VAL_WIDTH-1:0] val_arr_t;
  typedef logic [REG_NUM-1:0][ID_WIDTH-1:0]  tag_arr_t;
  typedef logic [REG_NUM-1:0]                busy_arr_t;

  typedef struct packed {
    logic                 en;
    logic [REG_WIDTH-1:0] rd;
    logic [VAL_WIDTH-1:0] res;
    logic [ID_WIDTH-1:0]  lab;
  } commit_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational source-operand read port with x0 forcing
// and same-cycle commit bypass.
module rf_read_port
  import register_file_pkg::*;
(
  input  logic [REG_WIDTH-1:0] idx,
  input  val_arr_t             regs_val,
  input  tag_arr_t             regs_tag,
  input  busy_arr_t            regs_busy,
  input  commit_t              commit,
  output logic [VAL_WIDTH-1:0] val,
  output logic [ID_WIDTH-1:0]  label,
  output logic                 busy
);

  logic zero;
  logic hit;

  assign zero = ~|idx;
  assign hit  = !zero && commit.en
             && commit.rd == idx
             && regs_busy[idx]
             && regs_tag[idx] == commit.lab;

  always_comb begin
    val   = regs_val[idx];
    label = regs_tag[idx];
    busy  = regs_busy[idx];
    unique case (1'b1)
      zero: begin
        val   = '0;
        label = '0;
        busy  = 1'b0;
      end
      hit: begin
        val  = commit.res;
        busy = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags,
// commit write-back and misprediction flush.
module register_file
  import register_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic [REG_WIDTH-1:0] rs1_idx,
  input  logic [REG_WIDTH-1:0] rs2_idx,
  output logic [VAL_WIDTH-1:0] rf_val1,
  output logic [VAL_WIDTH-1:0] rf_val2,
  output logic [ID_WIDTH-1:0]  rf_label1,
  output logic [ID_WIDTH-1:0]  rf_label2,
  output logic                 rf_busy1,
  output logic                 rf_busy2,
  input  logic                 rename_en,
  input  logic [REG_WIDTH-1:0] rename_rd,
  input  logic [ID_WIDTH-1:0]  rename_tag,
  input  logic                 commit_en,
  input  logic [REG_WIDTH-1:0] commit_rd,
  input  logic [VAL_WIDTH-1:0] commit_res,
  input  logic [ID_WIDTH-1:0]  commit_lab
);

  val_arr_t  vals;
  tag_arr_t  tags;
  busy_arr_t busy;
  commit_t   commit;

  assign commit = '{
    en:  commit_en,
    rd:  commit_rd,
    res: commit_res,
    lab: commit_lab
  };

  // Later assignments win: rename beats commit clear, flush beats both.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      vals <= '0;
      tags <= '0;
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_en && |commit_rd) begin
        vals[commit_rd] <= commit_res;
        if (tags[commit_rd] == commit_lab)
          busy[commit_rd] <= 1'b0;
      end
      if (rename_en && |rename_rd) begin
        busy[rename_rd] <= 1'b1;
        tags[rename_rd] <= rename_tag;
      end
      if (flush_in)
        busy <= '0;
    end
  end

  rf_read_port u_rd1 (
    .idx       (rs1_idx),
    .regs_val  (vals),
    .regs_tag  (tags),
    .regs_busy (busy),
    .commit    (commit),
    .val       (rf_val1),
    .label     (rf_label1),
    .busy      (rf_busy1)
  );

  rf_read_port u_rd2 (
    .idx       (rs2_idx),
    .regs_val  (vals),
    .regs_tag  (tags),
    .regs_busy (busy),
    .commit    (commit),
    .val       (rf_val2),
    .label     (rf_label2),
    .busy      (rf_busy2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: directed scenarios plus random traffic
// against an array-based model of the register file.
module tb_register_file;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rf_val1;
  logic [31:0] rf_val2;
  logic [3:0]  rf_label1;
  logic [3:0]  rf_label2;
  logic        rf_busy1;
  logic        rf_busy2;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_tag;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_res;
  logic [3:0]  commit_lab;

  register_file dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rf_val1    (rf_val1),
    .rf_val2    (rf_val2),
    .rf_label1  (rf_label1),
    .rf_label2  (rf_label2),
    .rf_busy1   (rf_busy1),
    .rf_busy2   (rf_busy2),
    .rename_en  (rename_en),
    .rename_rd  (rename_rd),
    .rename_tag (rename_tag),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_res (commit_res),
    .commit_lab (commit_lab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_val  [32];
  logic [3:0]  m_tag  [32];
  logic        m_busy [32];
  bit          m_ok = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", name, got, exp, $time);
    end
  endtask

  // What a decoder should observe for register r right now.
  function automatic void m_read(input int r,
                                 output logic [31:0] v,
                                 output logic [3:0] l,
                                 output logic b);
    v = m_val[r];
    l = m_tag[r];
    b = m_busy[r];
    if (r == 0) begin
      v = 0; l = 0; b = 0;
    end else if (commit_en && int'(commit_rd) == r
                 && m_busy[r] && m_tag[r] == commit_lab) begin
      v = commit_res;
      b = 0;
    end
  endfunction

  task automatic m_update();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
      end
      m_ok = 1;
    end else if (rdy_in) begin
      if (commit_en && commit_rd != 0) begin
        m_val[commit_rd] = commit_res;
        if (m_tag[commit_rd] == commit_lab) m_busy[commit_rd] = 0;
      end
      if (rename_en && rename_rd != 0 && !flush_in) begin
        m_busy[rename_rd] = 1;
        m_tag[rename_rd]  = rename_tag;
      end
      if (flush_in)
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end
  endtask

  task automatic settle();
    logic [31:0] v;
    logic [3:0]  l;
    logic        b;
    #1;
    if (m_ok) begin
      m_read(int'(rs1_idx), v, l, b);
      chk("val1", rf_val1, v);
      chk("busy1", {31'd0, rf_busy1}, {31'd0, b});
      if (b || rs1_idx == 0) chk("label1", {28'd0, rf_label1}, {28'd0, l});
      m_read(int'(rs2_idx), v, l, b);
      chk("val2", rf_val2, v);
      chk("busy2", {31'd0, rf_busy2}, {31'd0, b});
      if (b || rs2_idx == 0) chk("label2", {28'd0, rf_label2}, {28'd0, l});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; flush_in = 0;
    rename_en = 0; rename_rd = 0; rename_tag = 0;
    commit_en = 0; commit_rd = 0; commit_res = 0; commit_lab = 0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [3:0] t);
    rename_en = 1; rename_rd = rd; rename_tag = t;
  endtask

  task automatic com(input logic [4:0] rd, input logic [3:0] t,
                     input logic [31:0] res);
    commit_en = 1; commit_rd = rd; commit_lab = t; commit_res = res;
  endtask

  initial begin
    idle();
    rs1_idx = 5; rs2_idx = 31;
    rst_in = 1;
    tick(); tick();

    // T1 reset
    idle(); settle();
    chk("t1_val5", rf_val1, 0);
    chk("t1_busy5", {31'd0, rf_busy1}, 0);
    chk("t1_val31", rf_val2, 0);
    chk("t1_busy31", {31'd0, rf_busy2}, 0);
    tick();

    // T2 rename then commit with bypass
    idle(); rs1_idx = 3; ren(3, 7); settle();
    chk("t2_ren_hidden", {31'd0, rf_busy1}, 0);
    tick();
    idle(); settle();
    chk("t2_busy", {31'd0, rf_busy1}, 1);
    chk("t2_label", {28'd0, rf_label1}, 7);
    tick();
    idle(); com(3, 7, 32'hDEADBEEF); settle();
    chk("t2_byp_val", rf_val1, 32'hDEADBEEF);
    chk("t2_byp_busy", {31'd0, rf_busy1}, 0);
    tick();
    idle(); settle();
    chk("t2_stored", rf_val1, 32'hDEADBEEF);
    chk("t2_stored_busy", {31'd0, rf_busy1}, 0);
    tick();

    // T3 WAW
    idle(); rs1_idx = 4; ren(4, 2); settle(); tick();
    idle(); ren(4, 5); settle(); tick();
    idle(); com(4, 2, 32'h11); settle(); tick();
    idle(); settle();
    chk("t3_val", rf_val1, 32'h11);
    chk("t3_busy", {31'd0, rf_busy1}, 1);
    chk("t3_label", {28'd0, rf_label1}, 5);
    tick();
    idle(); com(4, 5, 32'h22); settle(); tick();
    idle(); settle();
    chk("t3_val2", rf_val1, 32'h22);
    chk("t3_busy2", {31'd0, rf_busy1}, 0);
    tick();

    // T4 rename/commit collision
    idle(); rs1_idx = 6; ren(6, 8); settle(); tick();
    idle(); ren(6, 9); com(6, 8, 32'h66); settle(); tick();
    idle(); settle();
    chk("t4_val", rf_val1, 32'h66);
    chk("t4_busy", {31'd0, rf_busy1}, 1);
    chk("t4_label", {28'd0, rf_label1}, 9);
    tick();

    // T5 flush
    idle(); rs1_idx = 7; rs2_idx = 8; ren(7, 1); settle(); tick();
    idle(); ren(8, 2); settle(); tick();
    idle(); flush_in = 1; com(7, 1, 32'h55); ren(9, 3); settle(); tick();
    idle(); settle();
    chk("t5_val7", rf_val1, 32'h55);
    chk("t5_busy7", {31'd0, rf_busy1}, 0);
    chk("t5_busy8", {31'd0, rf_busy2}, 0);
    tick();
    idle(); rs1_idx = 9; settle();
    chk("t5_busy9", {31'd0, rf_busy1}, 0);
    tick();

    // T6 x0 and rdy_in
    idle(); rs1_idx = 0; rs2_idx = 10;
    ren(0, 4); com(0, 0, 32'hFF); settle();
    chk("t6_x0_val", rf_val1, 0);
    chk("t6_x0_busy", {31'd0, rf_busy1}, 0);
    tick();
    idle(); settle();
    chk("t6_x0_val_after", rf_val1, 0);
    chk("t6_x0_label", {28'd0, rf_label1}, 0);
    tick();
    idle(); rdy_in = 0; com(10, 0, 32'h3); ren(11, 6); tick();
    idle(); rdy_in = 0; rs1_idx = 11; settle();
    chk("t6_frozen_val", rf_val2, 0);
    chk("t6_frozen_busy", {31'd0, rf_busy1}, 0);
    tick();
    idle(); com(10, 0, 32'h3); tick();
    idle(); settle();
    chk("t6_resumed", rf_val2, 32'h3);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_in     = ($urandom_range(299) == 0);
      rdy_in     = ($urandom_range(9) != 0);
      flush_in   = ($urandom_range(24) == 0);
      rename_en  = 1'($urandom_range(1));
      rename_rd  = 5'($urandom_range(7));
      rename_tag = 4'($urandom);
      commit_en  = 1'($urandom_range(1));
      commit_rd  = 5'($urandom_range(7));
      commit_res = $urandom;
      commit_lab = $urandom_range(2) != 0 ? m_tag[commit_rd]
                                          : 4'($urandom);
      rs1_idx    = 5'($urandom_range(7));
      rs2_idx    = $urandom_range(1) != 0 ? commit_rd : 5'($urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
